signal_generator: RTL

SIGNAL_GENERATOR -- requirements
Module: signal_generator

---
 rtl/signal_generator.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/signal_generator.sv
// rtl/signal_generator.sv - windowed pulse-train generator with BCD edge-count loader
// Optional window_start output: define SIGNAL_GENERATOR_WINDOW_OUT_EN.
module signal_generator #(
  parameter int UPDATE_PERIOD = 1199,
  parameter int BITS          = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] period,
  input  logic            period_load,
  input  logic [3:0]      tens,
  input  logic [3:0]      units,
  input  logic            load,
  output logic            busy,
  output logic            signal
`ifdef SIGNAL_GENERATOR_WINDOW_OUT_EN
  ,
  output logic            window_start
`endif
);

  typedef enum logic {IDLE, CONVERT} state_t;

  localparam logic [BITS-1:0] RST_PERIOD = BITS'(UPDATE_PERIOD);

  state_t          state_q, state_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      units_q, units_d;
  logic [6:0]      conv_acc_q, conv_acc_d;
  logic [6:0]      pend_cnt_q, pend_cnt_d;
  logic            pend_valid_q, pend_valid_d;
  logic [BITS-1:0] pend_period_q, pend_period_d;
  logic [BITS-1:0] p_active_q, p_active_d;
  logic [6:0]      n_active_q, n_active_d;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic [BITS:0]   acc_q, acc_d;
  logic            signal_q, signal_d;

  logic            wrap;
  logic [BITS:0]   win_len;
  logic [BITS:0]   n_limit;
  logic [BITS:0]   n_ext;
  logic [BITS:0]   n_eff;
  logic [BITS:0]   acc_in;
  logic [BITS:0]   acc_sum;
  logic            fire;

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Phase accumulator datapath: N is clamped to half the window so pulses never touch
  always_comb begin
    wrap    = (cnt_q == p_active_q);
    win_len = {1'b0, p_active_q} + 1'b1;
    n_limit = win_len >> 1;
    n_ext   = (BITS+1)'(n_active_q);
    n_eff   = (n_ext > n_limit) ? n_limit : n_ext;
    acc_in  = (cnt_q == '0) ? '0 : acc_q;
    acc_sum = acc_in + n_eff;
    fire    = (acc_sum >= win_len);
  end

  // Conversion FSM and pending-register next state
  always_comb begin
    state_d       = state_q;
    tens_d        = tens_q;
    units_d       = units_q;
    conv_acc_d    = conv_acc_q;
    pend_cnt_d    = pend_cnt_q;
    pend_valid_d  = wrap ? 1'b0 : pend_valid_q;
    pend_period_d = period_load ? period : pend_period_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          tens_d     = sat9(tens);
          units_d    = sat9(units);
          conv_acc_d = '0;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        if (tens_q != 4'd0) begin
          conv_acc_d = conv_acc_q + 7'd10;
          tens_d     = tens_q - 4'd1;
        end else begin
          // A fresh result wins over the clear from a coincident wrap
          pend_cnt_d   = conv_acc_q + {3'b000, units_q};
          pend_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window counter; new period/count take effect only at the wrap to 0
  always_comb begin
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    p_active_d = wrap ? pend_period_q : p_active_q;
    n_active_d = (wrap && pend_valid_q) ? pend_cnt_q : n_active_q;
    acc_d      = fire ? (acc_sum - win_len) : acc_sum;
    signal_d   = fire;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tens_q        <= '0;
      units_q       <= '0;
      conv_acc_q    <= '0;
      pend_cnt_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_period_q <= RST_PERIOD;
      p_active_q    <= RST_PERIOD;
      n_active_q    <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      signal_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      tens_q        <= tens_d;
      units_q       <= units_d;
      conv_acc_q    <= conv_acc_d;
      pend_cnt_q    <= pend_cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_period_q <= pend_period_d;
      p_active_q    <= p_active_d;
      n_active_q    <= n_active_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      signal_q      <= signal_d;
    end
  end

  assign busy   = (state_q == CONVERT);
  assign signal = signal_q;

`ifdef SIGNAL_GENERATOR_WINDOW_OUT_EN
  logic ws_q;

  // Registered marker for the cycle in which the window counter is 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ws_q <= 1'b0;
    else       ws_q <= (cnt_d == '0);
  end

  assign window_start = ws_q;
`endif

endmodule
